// File: rtl/src_timing_gen.sv
// Raster timing source: walks an h/v counter over a blanked frame, reads the source
// frame RAM in raster order and presents sync, enable and pixel data 3 cycles behind the counter.
//
//   state | meaning
//   IDLE  | waiting for run; cfg latched and checked on the run sample
//   RUN   | h/v counter walking the frame, relatches cfg at the frame wrap
//   DRAIN | 3 cycles letting the read/data pipeline empty
module src_timing_gen #(
  parameter int HFRONT = 2,
  parameter int HSYNC  = 1,
  parameter int HBACK  = 2,
  parameter int VFRONT = 1,
  parameter int VSYNC  = 1,
  parameter int VBACK  = 1,
  parameter int DIM_W  = 12,
  parameter int ADDR_W = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [DIM_W-1:0]  src_width,
  input  logic [DIM_W-1:0]  src_height,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_R,
  input  logic [7:0]        rd_G,
  input  logic [7:0]        rd_B,
  output logic              hsync,
  output logic              vsync,
  output logic              data_enable,
  output logic [7:0]        cur_R,
  output logic [7:0]        cur_G,
  output logic [7:0]        cur_B,
  output logic              frame_start,
  output logic              frame_end,
  output logic              busy,
  output logic              cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [DIM_W-1:0] HS_BEG  = DIM_W'(HFRONT);
  localparam logic [DIM_W-1:0] HS_END  = DIM_W'(HFRONT + HSYNC);
  localparam logic [DIM_W-1:0] HA_BEG  = DIM_W'(HFRONT + HSYNC + HBACK);
  localparam logic [DIM_W-1:0] VS_BEG  = DIM_W'(VFRONT);
  localparam logic [DIM_W-1:0] VS_END  = DIM_W'(VFRONT + VSYNC);
  localparam logic [DIM_W-1:0] VA_BEG  = DIM_W'(VFRONT + VSYNC + VBACK);
  localparam logic [DIM_W:0]   H_BLK_M1 = (DIM_W+1)'(HFRONT + HSYNC + HBACK - 1);
  localparam logic [DIM_W:0]   V_BLK_M1 = (DIM_W+1)'(VFRONT + VSYNC + VBACK - 1);

  state_t            state, state_nx;
  logic [DIM_W-1:0]  h, h_nx, v, v_nx;
  logic [DIM_W-1:0]  w_q, w_nx, ht_q, ht_nx;
  logic              err_nx;
  logic [1:0]        drain_cnt, drain_nx;

  logic              h_wrap, v_wrap, cfg_bad;
  logic              in_run, hsync_c, vsync_c, active_c, origin_c, last_c;

  // Last-position compares are one bit wider so W/H near full scale cannot overflow.
  assign h_wrap  = ({1'b0, h} == ({1'b0, w_q} + H_BLK_M1));
  assign v_wrap  = ({1'b0, v} == ({1'b0, ht_q} + V_BLK_M1));
  assign cfg_bad = (src_width == '0) || (src_height == '0);

  assign in_run   = (state == RUN);
  assign hsync_c  = in_run && (h >= HS_BEG) && (h < HS_END);
  assign vsync_c  = in_run && (v >= VS_BEG) && (v < VS_END);
  assign active_c = in_run && (h >= HA_BEG) && (v >= VA_BEG);
  assign origin_c = in_run && (h == '0) && (v == '0);
  assign last_c   = in_run && h_wrap && v_wrap;

  always_comb begin
    state_nx = state;
    h_nx     = h;
    v_nx     = v;
    w_nx     = w_q;
    ht_nx    = ht_q;
    err_nx   = cfg_err;
    drain_nx = drain_cnt;
    case (state)
      IDLE: begin
        if (run) begin
          w_nx  = src_width;
          ht_nx = src_height;
          if (cfg_bad) begin
            err_nx = 1'b1;
          end else begin
            state_nx = RUN;
            h_nx     = '0;
            v_nx     = '0;
          end
        end
      end
      RUN: begin
        if (h_wrap) begin
          h_nx = '0;
          if (v_wrap) begin
            v_nx = '0;
            if (run && !cfg_bad) begin
              w_nx  = src_width;
              ht_nx = src_height;
            end else begin
              if (run) begin
                w_nx   = src_width;
                ht_nx  = src_height;
                err_nx = 1'b1;
              end
              state_nx = DRAIN;
              drain_nx = 2'd2;
            end
          end else begin
            v_nx = v + 1'b1;
          end
        end else begin
          h_nx = h + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt == 2'd0) state_nx = IDLE;
        else                   drain_nx = drain_cnt - 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      h         <= '0;
      v         <= '0;
      w_q       <= '0;
      ht_q      <= '0;
      cfg_err   <= 1'b0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nx;
      h         <= h_nx;
      v         <= v_nx;
      w_q       <= w_nx;
      ht_q      <= ht_nx;
      cfg_err   <= err_nx;
      drain_cnt <= drain_nx;
    end
  end

  assign busy = (state != IDLE);

  logic [ADDR_W-1:0] pix;
  logic hs_d1, vs_d1, fs_d1, fe_d1;
  logic hs_d2, vs_d2, fs_d2, fe_d2, de_d2;

  // Stage 1 issues the read, stage 2 waits on the RAM, stage 3 registers the pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix         <= '0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      hs_d1       <= 1'b0;
      vs_d1       <= 1'b0;
      fs_d1       <= 1'b0;
      fe_d1       <= 1'b0;
      hs_d2       <= 1'b0;
      vs_d2       <= 1'b0;
      fs_d2       <= 1'b0;
      fe_d2       <= 1'b0;
      de_d2       <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      data_enable <= 1'b0;
      cur_R       <= '0;
      cur_G       <= '0;
      cur_B       <= '0;
    end else begin
      if (origin_c)      pix <= '0;
      else if (active_c) pix <= pix + 1'b1;
      rd_en <= active_c;
      if (active_c) rd_addr <= pix;
      hs_d1 <= hsync_c;
      vs_d1 <= vsync_c;
      fs_d1 <= origin_c;
      fe_d1 <= last_c;

      hs_d2 <= hs_d1;
      vs_d2 <= vs_d1;
      fs_d2 <= fs_d1;
      fe_d2 <= fe_d1;
      de_d2 <= rd_en;

      hsync       <= hs_d2;
      vsync       <= vs_d2;
      frame_start <= fs_d2;
      frame_end   <= fe_d2;
      data_enable <= de_d2;
      cur_R       <= de_d2 ? rd_R : 8'h00;
      cur_G       <= de_d2 ? rd_G : 8'h00;
      cur_B       <= de_d2 ? rd_B : 8'h00;
    end
  end

endmodule
